// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock datapath: BCD digit widths, digit
// limits and the {tens, ones} pair used by the timebase, the hour stage and
// the display driver.
package clock_pkg;

    localparam int unsigned BCD_W  = 4;
    localparam int unsigned TENS_W = 3;

    localparam logic [BCD_W-1:0]  ONES_MAX = 4'd9;
    localparam logic [TENS_W-1:0] TENS_MAX = 3'd5;

    typedef struct packed {
        logic [TENS_W-1:0] tens;
        logic [BCD_W-1:0]  ones;
    } bcd_pair_t;

endpackage

// File: rtl/mod_sixty_counter.sv
// Two-digit BCD counter 00..59, used for both seconds and minutes.
// Ports:
//   clockIn  in   rising-edge clock
//   reset    in   synchronous active-low reset (value -> 00)
//   inc      in   advance by one this edge (mod 60)
//   clr      in   force value to 00 this edge; wins over inc
//   ones     out  registered units digit, 0-9
//   tens     out  registered tens digit, 0-5
//   wrap     out  combinational: value is 59 and inc is asserted
module mod_sixty_counter
    import clock_pkg::*;
(
    input  logic              clockIn,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [BCD_W-1:0]  ones,
    output logic [TENS_W-1:0] tens,
    output logic              wrap
);

    bcd_pair_t val_q, val_d;
    logic      at_max;

    assign at_max = (val_q.tens == TENS_MAX) && (val_q.ones == ONES_MAX);
    assign wrap   = at_max && inc;
    assign ones   = val_q.ones;
    assign tens   = val_q.tens;

    always_comb begin
        // NOTE: default assignment first so every path drives val_d; a missing
        // else branch would otherwise infer a latch.
        val_d = val_q;
        if (clr) begin
            val_d = '0;
        end else if (inc) begin
            if (val_q.ones == ONES_MAX) begin
                val_d.ones = '0;
                val_d.tens = (val_q.tens == TENS_MAX) ? '0 : val_q.tens + TENS_W'(1);
            end else begin
                val_d.ones = val_q.ones + BCD_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clockIn) begin
        if (!reset) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

endmodule

// File: rtl/minute_second_timebase.sv
// Timebase feeding the hour counter: divides clockIn down to a 1 s tick and
// keeps mm:ss in BCD. hourAdv pulses when a seconds carry rolls minutes 59->00.
// Ports:
//   clockIn   in   system clock
//   reset     in   synchronous active-low reset
//   run       in   1 = prescaler counts, 0 = prescaler holds
//   incMin    in   pulse: minutes +1 (mod 60), seconds untouched
//   clrSec    in   pulse: prescaler and seconds cleared
//   secOnes/secTens/minOnes/minTens  out  registered BCD digits
//   secTick   out  registered pulse, coincident with each seconds increment
//   hourAdv   out  registered pulse, coincident with a carry-driven 59->00
module minute_second_timebase
    import clock_pkg::*;
#(
    parameter int unsigned DIV = 50000000
) (
    input  logic              clockIn,
    input  logic              reset,
    input  logic              run,
    input  logic              incMin,
    input  logic              clrSec,
    output logic [BCD_W-1:0]  secOnes,
    output logic [TENS_W-1:0] secTens,
    output logic [BCD_W-1:0]  minOnes,
    output logic [TENS_W-1:0] minTens,
    output logic              secTick,
    output logic              hourAdv
);

    localparam int unsigned    PW     = $clog2(DIV);
    localparam logic [PW-1:0]  P_LAST = PW'(DIV - 1);

    logic [PW-1:0] p_q, p_d;
    logic          tick;
    logic          sec_inc;
    logic          sec_wrap;
    logic          min_inc;
    logic          min_wrap;
    logic          sec_tick_q, sec_tick_d;
    logic          hour_adv_q, hour_adv_d;

    assign tick = run && (p_q == P_LAST);

    // clrSec suppresses the seconds step, so no carry (and no hourAdv) can
    // come out of a cleared cycle.
    assign sec_inc = tick && !clrSec;

    // Carry and incMin share one request: minutes move by exactly one.
    assign min_inc = sec_wrap || incMin;

    always_comb begin
        p_d = p_q;
        if (clrSec) begin
            p_d = '0;
        end else if (run) begin
            p_d = tick ? '0 : p_q + PW'(1);
        end
    end

    assign sec_tick_d = sec_inc;
    // Only a carry-driven wrap advances the hour; setting minutes never does.
    assign hour_adv_d = min_wrap && sec_wrap;

    always_ff @(posedge clockIn) begin
        if (!reset) begin
            p_q        <= '0;
            sec_tick_q <= 1'b0;
            hour_adv_q <= 1'b0;
        end else begin
            p_q        <= p_d;
            sec_tick_q <= sec_tick_d;
            hour_adv_q <= hour_adv_d;
        end
    end

    assign secTick = sec_tick_q;
    assign hourAdv = hour_adv_q;

    mod_sixty_counter u_seconds (
        .clockIn (clockIn),
        .reset   (reset),
        .inc     (sec_inc),
        .clr     (clrSec),
        .ones    (secOnes),
        .tens    (secTens),
        .wrap    (sec_wrap)
    );

    mod_sixty_counter u_minutes (
        .clockIn (clockIn),
        .reset   (reset),
        .inc     (min_inc),
        .clr     (1'b0),
        .ones    (minOnes),
        .tens    (minTens),
        .wrap    (min_wrap)
    );

endmodule

// File: tb/tb_minute_second_timebase.sv
// Directed bench for minute_second_timebase with DIV=4. A vector table covers
// reset and the first three seconds; hand-written sequences cover the minute
// wrap, minute setting, clrSec, run hold and mid-count reset.
module tb_minute_second_timebase;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n, run, inc_min, clr_sec;
    logic [3:0] sec_ones, min_ones;
    logic [2:0] sec_tens, min_tens;
    logic       sec_tick, hour_adv;
    logic [15:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    minute_second_timebase #(.DIV(DIV)) dut (
        .clockIn (clk),
        .reset   (reset_n),
        .run     (run),
        .incMin  (inc_min),
        .clrSec  (clr_sec),
        .secOnes (sec_ones),
        .secTens (sec_tens),
        .minOnes (min_ones),
        .minTens (min_tens),
        .secTick (sec_tick),
        .hourAdv (hour_adv)
    );

    assign obs = {sec_tens, sec_ones, min_tens, min_ones, sec_tick, hour_adv};

    typedef struct {
        logic rst_n;
        logic run;
        logic inc;
        logic clr;
        int   ss;
        int   mm;
        logic tick;
        logic hour;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [15:0] exp_v(int ss, int mm, logic t, logic h);
        return {3'(ss / 10), 4'(ss % 10), 3'(mm / 10), 4'(mm % 10), t, h};
    endfunction

    function automatic string fmt(logic [15:0] v);
        return $sformatf("%0d%0d:%0d%0d tick=%0b hour=%0b",
                         v[8:6], v[5:2], v[15:13], v[12:9], v[1], v[0]);
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic drive(input logic r, input logic ru, input logic inc, input logic clr);
        reset_n = r;
        run     = ru;
        inc_min = inc;
        clr_sec = clr;
    endtask

    // One rising edge, then settle so outputs are read away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Three reset edges with run=1, then twelve run edges after release.
        for (int i = 0; i < 3; i++) vecs[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        for (int e = 1; e <= 12; e++)
            vecs[2 + e] = '{1'b1, 1'b1, 1'b0, 1'b0, e / 4, 0, (e % 4) == 0, 1'b0};

        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst_n, vecs[i].run, vecs[i].inc, vecs[i].clr);
            step();
            check($sformatf("vec%0d", i), obs,
                  exp_v(vecs[i].ss, vecs[i].mm, vecs[i].tick, vecs[i].hour));
        end

        // Minute wrap by carry: preset 59:58, then two seconds.
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("reset_again", obs, exp_v(0, 0, 0, 0));
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        steps(59);
        check("preset_mm59", obs, exp_v(0, 59, 0, 0));
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        steps(58 * DIV);
        check("preset_5958", obs, exp_v(58, 59, 1, 0));
        steps(DIV);
        check("tick_5959", obs, exp_v(59, 59, 1, 0));
        steps(DIV - 1);
        check("pre_wrap", obs, exp_v(59, 59, 0, 0));
        step();
        check("wrap_hour_adv", obs, exp_v(0, 0, 1, 1));
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("wrap_pulse_ends", obs, exp_v(0, 0, 0, 0));

        // Minute wrap by incMin alone: seconds kept, no hourAdv.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        steps(2 * DIV);
        check("ss_02", obs, exp_v(2, 0, 1, 0));
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        steps(59);
        check("set_mm59", obs, exp_v(2, 59, 0, 0));
        step();
        check("set_wrap_no_hour", obs, exp_v(2, 0, 0, 0));

        // clrSec in the tick cycle at ss=59, p=DIV-1.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        steps(57 * DIV);
        check("ss_59", obs, exp_v(59, 0, 1, 0));
        steps(DIV - 1);
        check("p_last", obs, exp_v(59, 0, 0, 0));
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        step();
        check("clr_in_tick", obs, exp_v(0, 0, 0, 0));
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        steps(DIV - 1);
        check("clr_no_early_tick", obs, exp_v(0, 0, 0, 0));
        step();
        check("clr_next_tick", obs, exp_v(1, 0, 1, 0));

        // clrSec with incMin: seconds cleared and minutes +1.
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        step();
        check("clr_and_inc", obs, exp_v(0, 1, 0, 0));

        // Carry and incMin on the same edge: minutes advance once.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        steps(59 * DIV);
        check("ss_59_mm01", obs, exp_v(59, 1, 1, 0));
        steps(DIV - 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        check("carry_plus_inc", obs, exp_v(0, 2, 1, 0));

        // run=0 holds the prescaler; resume continues from the held count.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        steps(2);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("hold%0d", i), obs, exp_v(0, 2, 0, 0));
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("resume_edge1", obs, exp_v(0, 2, 0, 0));
        step();
        check("resume_tick", obs, exp_v(1, 2, 1, 0));

        // Reset mid-count clears everything; prescaler restarts from zero.
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("mid_reset", obs, exp_v(0, 0, 0, 0));
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        steps(DIV - 1);
        check("post_reset_no_tick", obs, exp_v(0, 0, 0, 0));
        step();
        check("post_reset_tick", obs, exp_v(1, 0, 1, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
